rx_byte_assembler: RTL
======================

Name: rx_byte_assembler

Overview:
- Downstream neighbour of the RX bit-stuff detector in the CDL USB receive path.
- Consumes the NRZI-decoded bit stream, the per-bit sample strobe and the stuff detector's ignore_bit, and drops stuffed bits.
- Assembles LSB-first serial bits into bytes and hands each byte to the RX control unit through a valid/ack holding register.
- Reports stuff errors, partial bytes at EOP, and overruns to the control unit.

Parameters:
- DATA_W, 8, width of assembled word and holding register.
- CNT_W, 3, width of the bit counter; must equal clog2(DATA_W).

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  reset, asynchronous, active-low
- shift_enable  input  1  one-cycle strobe at each bit sample point
- decoded_bit  input  1  NRZI-decoded bit, valid when shift_enable=1
- ignore_bit  input  1  from the stuff detector; current bit is a stuff bit
- eop  input  1  end-of-packet seen at this sample point
- rcving  input  1  control unit: packet in progress, sync already consumed
- clear  input  1  synchronous clear of counter and flags, one cycle
- data_ack  input  1  control unit has consumed rx_data
- rx_data  output  DATA_W  last completed byte, held until overwritten
- data_valid  output  1  rx_data holds an unconsumed byte
- byte_done  output  1  one-cycle pulse when a byte completes
- stuff_error  output  1  sticky; a stuff bit was 1
- partial_byte  output  1  sticky; EOP arrived with 1..7 bits accumulated
- overrun  output  1  sticky; unconsumed byte was overwritten

Behaviour:
- Reset: all outputs 0; shift register 0; bit_cnt 0; state IDLE.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT when rcving=1.
  - SHIFT -> DONE on shift_enable & eop.
  - SHIFT -> IDLE when rcving=0. This is an abort: bit_cnt is cleared and partial_byte is not set.
  - DONE -> IDLE when rcving=0.
- Strobes act only in SHIFT. Strobes in IDLE and DONE are ignored.
- Accepted bit: SHIFT & shift_enable & !ignore_bit & !eop.
  - Shift right with decoded_bit into the MSB (USB is LSB first).
  - bit_cnt increments.
- Stuff bit: SHIFT & shift_enable & ignore_bit & !eop.
  - No shift and no count.
  - If decoded_bit=1, set stuff_error.
- Byte completion: an accepted bit with bit_cnt=DATA_W-1.
  - On the next edge: rx_data <= completed word, data_valid <= 1, byte_done pulses for one cycle, bit_cnt wraps to 0.
  - Latency is 1 cycle from the 8th strobe to byte_done and data_valid.
- EOP handling: SHIFT & shift_enable & eop.
  - If bit_cnt != 0, set partial_byte.
  - bit_cnt <= 0, and the shift register is discarded.
  - eop takes priority over ignore_bit.
- Handshake:
  - data_ack while data_valid=1 clears data_valid on the next edge.
  - data_ack while data_valid=0 has no effect.
- Completion while data_valid=1 and no data_ack that cycle: new byte overwrites rx_data, data_valid stays 1, overrun set.
- Completion and data_ack in the same cycle: new byte loaded, data_valid stays 1, no overrun.
- clear:
  - Zeroes bit_cnt, the shift register, stuff_error, partial_byte, overrun and data_valid.
  - Does not change state and does not change rx_data.
  - Beats any simultaneous strobe or completion that cycle; byte_done is not pulsed.
- Sticky flags hold until clear or reset.
- Asynchronous reset mid-byte: everything returns to reset values immediately.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package rx_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} asm_state_t
  - localparam RX_DATA_W=8
  - localparam RX_CNT_W=3
- One natural sub-module: rx_bit_counter.
  - CNT_W-wide counter with enable, sync clear and wrap.
  - Outputs count and rollover_flag (high when count=DATA_W-1 and enable).

Test Plan:
- Basic byte: rcving=1, strobes with bits 1,0,1,0,0,1,0,1, ignore_bit=0 -> 1 cycle after the 8th strobe: rx_data=0xA5, data_valid=1, byte_done high for exactly 1 cycle, no flags set.
- Stuffed byte: bits 1,1,1,1,1,1, then stuff bit 0 with ignore_bit=1, then 1,1 -> rx_data=0xFF after 9 strobes, stuff_error=0.
- Stuff error: same sequence but the stuff bit is 1 -> stuff_error=1 and still 1 after the byte completes; clear -> stuff_error=0.
- Overrun and same-cycle ack:
  - Send 0x3C without ack, then 0xC3 -> rx_data=0xC3, overrun=1.
  - Repeat after clear with data_ack asserted on the completion cycle -> data_valid=1, overrun=0.
- Partial EOP: 3 bits accepted, then shift_enable with eop=1 -> partial_byte=1, state DONE, no byte_done; later strobes ignored until rcving=0 -> IDLE.
- Clear mid-byte: 5 bits, then clear coinciding with a strobe -> bit_cnt=0; next 8 bits 0x5A -> rx_data=0x5A. Assert n_rst low mid-byte -> all outputs 0 immediately.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and widths for the USB RX byte assembly path.
// Holds the assembler FSM encoding and the default data/counter widths.
// Imported by rx_bit_counter and rx_byte_assembler.
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } asm_state_t;

  localparam int RX_DATA_W = 8;
  localparam int RX_CNT_W  = 3;

endpackage

// File: rtl/rx_bit_counter.sv
// Bit position counter for the byte assembler: counts accepted bits, wraps at DATA_W-1.
// Latency: count updates on the edge after i_en; o_rollover_flag is combinational from count and i_en.
// No backpressure: i_clr beats i_en, the counter never stalls.
module rx_bit_counter
  import rx_pkg::*;
#(
  parameter int DATA_W = RX_DATA_W,
  parameter int CNT_W  = RX_CNT_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_rollover_flag
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_last;

  assign w_at_last       = (r_count == LAST);
  assign o_rollover_flag = i_en & w_at_last;
  assign o_count         = r_count;

  // Count enabled bits, wrapping to zero after the last bit of a word; clear wins.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_at_last ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/rx_byte_assembler.sv
// Drops stuffed bits, assembles LSB-first bits into bytes and holds them for the RX control unit.
// Latency: byte_done/data_valid rise 1 cycle after the strobe carrying the last bit of a byte.
// No backpressure on the bit stream: an unacked byte is overwritten and overrun is flagged.
module rx_byte_assembler
  import rx_pkg::*;
#(
  parameter int DATA_W = RX_DATA_W,
  parameter int CNT_W  = RX_CNT_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              shift_enable,
  input  logic              decoded_bit,
  input  logic              ignore_bit,
  input  logic              eop,
  input  logic              rcving,
  input  logic              clear,
  input  logic              data_ack,
  output logic [DATA_W-1:0] rx_data,
  output logic              data_valid,
  output logic              byte_done,
  output logic              stuff_error,
  output logic              partial_byte,
  output logic              overrun
);

  asm_state_t        r_state;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_data_valid;
  logic              r_byte_done;
  logic              r_stuff_error;
  logic              r_partial_byte;
  logic              r_overrun;

  logic              w_strobe;
  logic              w_in_shift;
  logic              w_abort;
  logic              w_eop_hit;
  logic              w_accept;
  logic              w_stuff;
  logic              w_cnt_clr;
  logic              w_rollover;
  logic              w_complete;
  logic [CNT_W-1:0]  w_count;
  logic [DATA_W-1:0] w_next_word;

  // A clear in the same cycle swallows the strobe, so nothing it would cause happens.
  assign w_strobe    = shift_enable & ~clear;
  // Losing rcving while shifting is an abort and takes priority over any strobe.
  assign w_in_shift  = (r_state == SHIFT) & rcving;
  assign w_abort     = (r_state == SHIFT) & ~rcving;
  assign w_eop_hit   = w_in_shift & w_strobe & eop;
  assign w_accept    = w_in_shift & w_strobe & ~ignore_bit & ~eop;
  assign w_stuff     = w_in_shift & w_strobe & ignore_bit & ~eop;
  assign w_cnt_clr   = clear | w_eop_hit | w_abort;
  assign w_complete  = w_accept & w_rollover;
  // USB sends LSB first: new bits enter at the MSB and walk down.
  assign w_next_word = {decoded_bit, r_shift[DATA_W-1:1]};

  rx_bit_counter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_bit_counter (
    .clk             (clk),
    .n_rst           (n_rst),
    .i_en            (w_accept),
    .i_clr           (w_cnt_clr),
    .o_count         (w_count),
    .o_rollover_flag (w_rollover)
  );

  // Assembler FSM with registered data path, handshake and sticky status flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= IDLE;
      r_shift        <= '0;
      r_rx_data      <= '0;
      r_data_valid   <= 1'b0;
      r_byte_done    <= 1'b0;
      r_stuff_error  <= 1'b0;
      r_partial_byte <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_byte_done <= w_complete;

      case (r_state)
        IDLE:    if (rcving) r_state <= SHIFT;
        SHIFT: begin
          if (!rcving)        r_state <= IDLE;
          else if (w_eop_hit) r_state <= DONE;
        end
        DONE:    if (!rcving) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (clear) begin
        // rx_data is left alone so the last byte stays readable after a clear.
        r_shift        <= '0;
        r_data_valid   <= 1'b0;
        r_stuff_error  <= 1'b0;
        r_partial_byte <= 1'b0;
        r_overrun      <= 1'b0;
      end else begin
        if (w_eop_hit || w_abort) r_shift <= '0;
        else if (w_accept)        r_shift <= w_next_word;

        if (w_stuff && decoded_bit) r_stuff_error <= 1'b1;

        if (w_eop_hit && (w_count != '0)) r_partial_byte <= 1'b1;

        if (w_complete) begin
          r_rx_data    <= w_next_word;
          r_data_valid <= 1'b1;
          // A same-cycle ack means the old byte was consumed in time.
          if (r_data_valid && !data_ack) r_overrun <= 1'b1;
        end else if (data_ack) begin
          r_data_valid <= 1'b0;
        end
      end
    end
  end

  assign rx_data      = r_rx_data;
  assign data_valid   = r_data_valid;
  assign byte_done    = r_byte_done;
  assign stuff_error  = r_stuff_error;
  assign partial_byte = r_partial_byte;
  assign overrun      = r_overrun;

endmodule
